// File: rtl/comet_ii_pr_sp_unit.sv
// COMET II program-register / stack-pointer unit: owns PR and SP and sequences
// the single-word stack accesses needed by call, ret, push and pop.
module comet_ii_pr_sp_unit #(
  parameter logic [15:0] RESET_PR = 16'h0000,
  parameter logic [15:0] RESET_SP = 16'h0000
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        init,
  input  logic        inc_PR,
  input  logic        jump,
  input  logic        call,
  input  logic        ret,
  input  logic        push,
  input  logic        pop,
  input  logic        dec_SP,
  input  logic [15:0] adr,
  input  logic [15:0] rdata,
  input  logic        stk_gnt,
  output logic [15:0] PR,
  output logic [15:0] SP,
  output logic        stk_req,
  output logic        stk_we,
  output logic [15:0] stk_adr,
  output logic [15:0] stk_wdata,
  output logic [15:0] pop_data,
  output logic        pop_valid,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;
  localparam logic [1:0] RDW  = 2'd3;

  logic [1:0]  state;
  logic [15:0] pr_q;
  logic [15:0] sp_q;
  logic [15:0] pop_data_q;
  logic [15:0] wdata_q;
  logic [15:0] target_q;
  logic        op_call;
  logic        op_ret;

  // Control and architectural state; every command is decided here in IDLE.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pr_q       <= RESET_PR;
      sp_q       <= RESET_SP;
      pop_data_q <= 16'h0000;
      op_call    <= 1'b0;
      op_ret     <= 1'b0;
    end else if (init) begin
      state      <= IDLE;
      pr_q       <= RESET_PR;
      sp_q       <= RESET_SP;
      pop_data_q <= 16'h0000;
      op_call    <= 1'b0;
      op_ret     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (call) begin
            sp_q    <= sp_q - 16'd1;
            op_call <= 1'b1;
            state   <= WR;
          end else if (ret) begin
            op_ret <= 1'b1;
            state  <= RD;
          end else if (push) begin
            sp_q    <= sp_q - 16'd1;
            op_call <= 1'b0;
            state   <= WR;
          end else if (pop) begin
            op_ret <= 1'b0;
            state  <= RD;
          end else if (jump) begin
            pr_q <= adr;
          end else if (inc_PR) begin
            pr_q <= pr_q + 16'd1;
          end else if (dec_SP) begin
            sp_q <= sp_q - 16'd1;
          end
        end
        WR: begin
          if (stk_gnt) begin
            if (op_call) pr_q <= target_q;
            state <= IDLE;
          end
        end
        RD: begin
          if (stk_gnt) state <= RDW;
        end
        default: begin
          sp_q <= sp_q + 16'd1;
          if (op_ret) pr_q <= rdata;
          else        pop_data_q <= rdata;
          state <= IDLE;
        end
      endcase
    end
  end

  // Operand capture: only observable through stk_wdata/PR once WR is entered.
  always_ff @(posedge mclk) begin
    if (state == IDLE) begin
      if (call) begin
        wdata_q  <= pr_q;
        target_q <= adr;
      end else if (!ret && push) begin
        wdata_q <= adr;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign stk_req   = (state == WR) || (state == RD);
  assign stk_we    = (state == WR);
  assign stk_adr   = stk_req ? sp_q : 16'h0000;
  assign stk_wdata = (state == WR) ? wdata_q : 16'h0000;
  assign pop_valid = (state == RDW) && !op_ret;
  assign pop_data  = pop_data_q;
  assign PR        = pr_q;
  assign SP        = sp_q;

endmodule

// File: tb/tb_comet_ii_pr_sp_unit.sv
// Bench for comet_ii_pr_sp_unit: directed steps plus randomized commands
// checked against a stack-semantics model with its own memory image.
module tb_comet_ii_pr_sp_unit;

  localparam logic [15:0] RST_PR = 16'h0000;
  localparam logic [15:0] RST_SP = 16'h0000;
  localparam logic [6:0] M_INC  = 7'h01;
  localparam logic [6:0] M_JMP  = 7'h02;
  localparam logic [6:0] M_CALL = 7'h04;
  localparam logic [6:0] M_RET  = 7'h08;
  localparam logic [6:0] M_PUSH = 7'h10;
  localparam logic [6:0] M_POP  = 7'h20;
  localparam logic [6:0] M_DEC  = 7'h40;

  logic        mclk = 1'b0;
  logic        rst = 1'b0;
  logic        init = 1'b0;
  logic        inc_PR = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0;
  logic        push = 1'b0, pop = 1'b0, dec_SP = 1'b0;
  logic [15:0] adr = 16'h0000;
  logic [15:0] rdata = 16'h0000;
  logic        stk_gnt = 1'b0;
  logic [15:0] PR, SP, stk_adr, stk_wdata, pop_data;
  logic        stk_req, stk_we, pop_valid, busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_pr, exp_sp;
  logic [15:0] mm  [0:65535];
  logic [15:0] ram [0:65535];

  comet_ii_pr_sp_unit #(.RESET_PR(RST_PR), .RESET_SP(RST_SP)) dut (
    .mclk(mclk), .rst(rst), .init(init),
    .inc_PR(inc_PR), .jump(jump), .call(call), .ret(ret),
    .push(push), .pop(pop), .dec_SP(dec_SP),
    .adr(adr), .rdata(rdata), .stk_gnt(stk_gnt),
    .PR(PR), .SP(SP), .stk_req(stk_req), .stk_we(stk_we),
    .stk_adr(stk_adr), .stk_wdata(stk_wdata),
    .pop_data(pop_data), .pop_valid(pop_valid), .busy(busy)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [6:0] m);
    inc_PR = m[0]; jump = m[1]; call = m[2]; ret = m[3];
    push   = m[4]; pop  = m[5]; dec_SP = m[6];
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".req"}, 32'(stk_req), 32'd0);
    check({tag, ".adr"}, 32'(stk_adr), 32'd0);
    check({tag, ".wdata"}, 32'(stk_wdata), 32'd0);
    check({tag, ".pv"}, 32'(pop_valid), 32'd0);
  endtask

  // Issue one command mask in an IDLE cycle, service the stack memory with a
  // grant after dly wait cycles, optionally spray ignored strobes while busy.
  task automatic run_op(input logic [6:0] m, input logic [15:0] a, input int dly, input bit noise);
    bit is_wr, is_rd, is_pop, rd_pending;
    logic [15:0] e_adr, e_wdat, e_pop, rd_adr;
    int busy_cyc, pulses, nwr, w, exp_cyc;
    logic [6:0] nz;
    is_wr = 0; is_rd = 0; is_pop = 0;
    e_adr = 16'h0; e_wdat = 16'h0; e_pop = 16'h0;
    // Reference: priority call > ret > push > pop > jump > inc_PR > dec_SP
    if (m[2]) begin
      is_wr = 1; exp_sp = exp_sp - 16'd1; e_adr = exp_sp; e_wdat = exp_pr;
      mm[exp_sp] = exp_pr; exp_pr = a;
    end else if (m[3]) begin
      is_rd = 1; e_adr = exp_sp; exp_pr = mm[exp_sp]; exp_sp = exp_sp + 16'd1;
    end else if (m[4]) begin
      is_wr = 1; exp_sp = exp_sp - 16'd1; e_adr = exp_sp; e_wdat = a; mm[exp_sp] = a;
    end else if (m[5]) begin
      is_rd = 1; is_pop = 1; e_adr = exp_sp; e_pop = mm[exp_sp]; exp_sp = exp_sp + 16'd1;
    end else if (m[1]) exp_pr = a;
    else if (m[0]) exp_pr = exp_pr + 16'd1;
    else if (m[6]) exp_sp = exp_sp - 16'd1;
    exp_cyc = is_wr ? dly + 1 : (is_rd ? dly + 2 : 0);

    set_cmd(m); adr = a;
    @(posedge mclk); #1;
    set_cmd(7'h00); adr = 16'($urandom);
    busy_cyc = 0; pulses = 0; nwr = 0; w = 0; rd_pending = 0; rd_adr = 16'h0;
    while (busy && busy_cyc < 40) begin
      busy_cyc++;
      if (rd_pending) begin rdata = ram[rd_adr]; rd_pending = 0; end
      if (pop_valid) pulses++;
      if (stk_req) begin
        check("req.we", 32'(stk_we), 32'(is_wr));
        check("req.adr", 32'(stk_adr), 32'(e_adr));
        if (stk_we) check("req.wdata", 32'(stk_wdata), 32'(e_wdat));
        stk_gnt = (w == dly); w++;
        if (stk_gnt) begin
          if (stk_we) begin ram[stk_adr] = stk_wdata; nwr++; end
          else begin rd_pending = 1; rd_adr = stk_adr; end
        end
      end else begin
        stk_gnt = noise ? 1'($urandom) : 1'b0;
      end
      if (noise) begin nz = 7'($urandom); set_cmd(nz); adr = 16'($urandom); end
      @(posedge mclk); #1;
    end
    set_cmd(7'h00); stk_gnt = 1'b0; rdata = 16'($urandom);
    check("op.cycles", 32'(busy_cyc), 32'(exp_cyc));
    check("op.PR", 32'(PR), 32'(exp_pr));
    check("op.SP", 32'(SP), 32'(exp_sp));
    check("op.pv_pulses", 32'(pulses), 32'(is_pop));
    if (is_wr) check("op.writes", 32'(nwr), 32'd1);
    if (is_pop) check("op.pop_data", 32'(pop_data), 32'(e_pop));
    check("op.idle_req", 32'(stk_req), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mm[i]  = 16'(i) ^ 16'h5A5A;
      ram[i] = 16'(i) ^ 16'h5A5A;
    end
    exp_pr = RST_PR; exp_sp = RST_SP;

    // Reset state while rst is held low
    #3;
    check_idle_outputs("reset");
    check("reset.PR", 32'(PR), 32'(RST_PR));
    check("reset.SP", 32'(SP), 32'(RST_SP));
    check("reset.pop_data", 32'(pop_data), 32'd0);
    #9 rst = 1'b1;
    @(posedge mclk); #1;

    // Three increments from reset
    for (int i = 0; i < 3; i++) run_op(M_INC, 16'h0, 0, 0);
    check("inc3.PR", 32'(PR), 32'h3);
    check("inc3.SP", 32'(SP), 32'h0);

    // Call/ret round trip with zero-wait grants
    run_op(M_JMP, 16'h0010, 0, 0);
    run_op(M_CALL, 16'h0200, 0, 0);
    check("call.PR", 32'(PR), 32'h0200);
    check("call.SP", 32'(SP), 32'hFFFF);
    check("call.mem", 32'(ram[16'hFFFF]), 32'h0010);
    run_op(M_RET, 16'h0, 0, 0);
    check("ret.PR", 32'(PR), 32'h0010);
    check("ret.SP", 32'(SP), 32'h0000);

    // Push/pop with a 3-cycle grant delay
    run_op(M_PUSH, 16'hABCD, 3, 0);
    check("push.mem", 32'(ram[16'hFFFF]), 32'hABCD);
    run_op(M_POP, 16'h0, 3, 0);
    check("pop.data", 32'(pop_data), 32'hABCD);
    check("pop.SP", 32'(SP), 32'h0000);

    // Priority: push wins over jump and inc_PR
    run_op(M_JMP | M_INC | M_PUSH, 16'h1111, 1, 0);
    check("prio.PR", 32'(PR), 32'h0010);
    run_op(M_CALL | M_RET | M_POP, 16'h2222, 0, 0);
    run_op(M_JMP | M_INC | M_DEC, 16'h3333, 0, 0);
    run_op(M_INC | M_DEC, 16'h0, 0, 0);

    // Strobes while busy are ignored
    run_op(M_PUSH, 16'h5555, 2, 1);
    run_op(M_POP, 16'h0, 2, 1);

    // Wraparound of PR and SP
    run_op(M_JMP, 16'hFFFF, 0, 0);
    run_op(M_INC, 16'h0, 0, 0);
    check("wrap.PR", 32'(PR), 32'h0000);
    while (SP != 16'h0000 && exp_sp != 16'h0000) run_op(M_POP, 16'h0, 0, 0);
    run_op(M_DEC, 16'h0, 0, 0);
    check("wrap.SP", 32'(SP), 32'hFFFF);
    run_op(M_POP, 16'h0, 0, 0);
    check("wrap.SP_up", 32'(SP), 32'h0000);

    // Randomized command mix
    for (int i = 0; i < 200; i++)
      run_op(7'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1);

    // Synchronous abort during RD
    run_op(M_JMP, 16'h1234, 0, 0);
    run_op(M_DEC, 16'h0, 0, 0);
    set_cmd(M_POP);
    @(posedge mclk); #1;
    set_cmd(7'h00);
    check("abort.in_rd", 32'(stk_req), 32'd1);
    init = 1'b1;
    @(posedge mclk); #1;
    init = 1'b0;
    exp_pr = RST_PR; exp_sp = RST_SP;
    check_idle_outputs("init");
    check("init.PR", 32'(PR), 32'(RST_PR));
    check("init.SP", 32'(SP), 32'(RST_SP));

    // Asynchronous reset during RD
    run_op(M_JMP, 16'h4321, 0, 0);
    run_op(M_DEC, 16'h0, 0, 0);
    set_cmd(M_RET);
    @(posedge mclk); #1;
    set_cmd(7'h00);
    check("arst.in_rd", 32'(stk_req), 32'd1);
    rst = 1'b0;
    #2;
    exp_pr = RST_PR; exp_sp = RST_SP;
    check_idle_outputs("arst");
    check("arst.PR", 32'(PR), 32'(RST_PR));
    check("arst.SP", 32'(SP), 32'(RST_SP));
    #4 rst = 1'b1;
    @(posedge mclk); #1;
    check_idle_outputs("arst_rel");
    run_op(M_PUSH, 16'h0BEE, 1, 0);
    check("arst_rel.SP", 32'(SP), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/comet_ii_pr_sp_unit.md
# comet_ii_pr_sp_unit

Program-register and stack-pointer unit for the COMET II CPU. It sits directly downstream of the CPU controller and consumes the controller's `inc_PR`, `jump`, `call`, `ret`, `push`, `pop`, `dec_SP` strobes and its 16-bit effective address. It owns PR and SP and sequences the multi-cycle stack memory accesses those strobes require. It holds `busy` high to stall the controller while a stack access is in flight.

## Interface
Parameters:
- `RESET_PR`, default 16'h0000: PR value after reset or `init`.
- `RESET_SP`, default 16'h0000: SP value after reset or `init`. The first push writes 16'hFFFF.

Ports:
- `mclk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `init`, in, 1: synchronous re-initialise. Loads the reset values and aborts any operation.
- `inc_PR`, `jump`, `call`, `ret`, `push`, `pop`, `dec_SP`, in, 1 each: command strobes from the controller.
- `adr`, in, 16: effective address, used as the jump/call target or the push value.
- `rdata`, in, 16: stack memory read data, valid the cycle after a read grant.
- `stk_gnt`, in, 1: the memory accepted the current `stk_req` this cycle.
- `PR`, out, 16: program register.
- `SP`, out, 16: stack pointer.
- `stk_req`, out, 1: stack memory request.
- `stk_we`, out, 1: 1 means write, 0 means read; valid while `stk_req` is high.
- `stk_adr`, out, 16: stack memory address.
- `stk_wdata`, out, 16: stack write data.
- `pop_data`, out, 16: word returned by POP.
- `pop_valid`, out, 1: one-cycle pulse when `pop_data` updates.
- `busy`, out, 1: an operation is in progress; new commands are ignored.

## Operation
- States: IDLE, WR (stack write pending), RD (stack read pending), RDW (read data wait).
- Commands are sampled only in IDLE. Commands asserted while `busy` is high are ignored.
- Priority when several strobes are high in the same cycle: `call` > `ret` > `push` > `pop` > `jump` > `inc_PR` > `dec_SP`. Only the winner executes.
- `inc_PR`: PR ← PR+1. Stay in IDLE.
- `jump`: PR ← `adr`. Stay in IDLE.
- `dec_SP`: SP ← SP−1. No memory access. Stay in IDLE.
- `push`: SP ← SP−1 and wdata register ← `adr`. Go to WR.
- `call`: SP ← SP−1, wdata register ← PR (pre-call value), target register ← `adr`. Go to WR.
  - PR ← target on the grant cycle's edge.
- `ret` and `pop`: latch the operation kind. Go to RD.
- WR: drive `stk_req`=1, `stk_we`=1, `stk_adr`=SP, `stk_wdata`=wdata register. Hold these until `stk_gnt`=1, then go to IDLE.
- RD: drive `stk_req`=1, `stk_we`=0, `stk_adr`=SP. Hold until `stk_gnt`=1, then go to RDW.
- RDW: capture `rdata` and set SP ← SP+1.
  - For `ret`: PR ← `rdata`.
  - For `pop`: `pop_data` ← `rdata` and `pop_valid`=1 for this cycle.
  - Go to IDLE.
- Arithmetic: all PR and SP arithmetic is modulo 2^16. 16'h0000−1 wraps to 16'hFFFF; 16'hFFFF+1 wraps to 16'h0000. There is no overflow flag.
- `stk_adr` and `stk_wdata` are 0 whenever `stk_req`=0.

## Timing
- Reset values (`rst` low, asynchronous): PR=`RESET_PR`, SP=`RESET_SP`, state IDLE.
  - `stk_req`, `stk_we`, `pop_valid`, `busy` = 0.
  - `stk_adr`, `stk_wdata`, `pop_data` = 0.
- `init`=1 produces the same values on the next edge and has priority over any state. If a request is in flight, `stk_req` falls the cycle after `init` is sampled.
- `rst` asserted mid-operation immediately clears all state. No partial SP or PR update survives.
- Single-cycle commands (`inc_PR`, `jump`, `dec_SP`): the result is visible in the cycle after the strobe. `busy` stays 0.
- Push/call accepted in cycle T:
  - `busy`=1 and `stk_req`=1 from T+1, with the new SP already visible.
  - On a zero-wait grant at T+1, the unit is IDLE at T+2, and for `call` PR=target at T+2.
- Pop/ret accepted in cycle T:
  - `stk_req` from T+1.
  - Grant at G, then RDW at G+1.
  - PR, SP and `pop_data` are updated at G+2. `pop_valid` is high in cycle G+1, with `pop_data` registered for G+2.
- `busy` = (state ≠ IDLE). It is combinational from state, so it is asserted from T+1 through the last cycle of the operation.
- `stk_gnt` is ignored outside WR and RD.

## Test plan
- Reset and `inc_PR`: release `rst`, then pulse `inc_PR` 3 times → PR=3, SP=0, `busy` never high.
- Call/ret round trip:
  - Setup: PR=16'h0010; `call` with `adr`=16'h0200; `stk_gnt` tied to 1.
  - Required after the call: write to 16'hFFFF with data 16'h0010; SP=16'hFFFF; PR=16'h0200.
  - Then `ret` with memory returning 16'h0010 → PR=16'h0010, SP=16'h0000.
- Push/pop with grant delayed 3 cycles:
  - `push` with `adr`=16'hABCD → `stk_req`/`stk_adr`=16'hFFFF held stable for 4 cycles.
  - Then `pop` → `pop_data`=16'hABCD with a single `pop_valid` pulse; SP=16'h0000.
- Priority: `jump`, `inc_PR` and `push` asserted in the same cycle → only the push executes; PR is unchanged.
- Commands while busy: pulse `jump` while in WR → PR is unchanged after completion.
- Abort: assert `init` during RD → next cycle `stk_req`=0, PR=`RESET_PR`, SP=`RESET_SP`.
  - Repeat with `rst` low → outputs clear asynchronously, before the next clock edge.
